gate_route_sched: RTL

- Scheduler and owner of the receive-side route capability table in the VIU network path.
- Serialises host capability writes (control channel) and route lookups from N_REQ receive requesters through a single lookup engine.
- Round-robin arbitration between requesters; host writes have bounded priority.
- Each lookup returns allow/deny plus destination port over a valid/ready response channel.

---
 rtl/gate_route_sched_pkg.sv | 31 +++
 rtl/gate_route_sched_arb.sv | 34 +++
 rtl/gate_route_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gate_route_sched_pkg.sv
// Shared types for the receive-side route gate: route word layout,
// scheduler state encoding and field extraction helpers.
package gate_route_sched_pkg;

  localparam int ROUTE_BITS     = 14;
  localparam int ROUTE_UL_LSB   = 6;
  localparam int ROUTE_UL_W     = 4;
  localparam int ROUTE_PORT_LSB = 0;
  localparam int ROUTE_PORT_W   = 2;
  // Table storage is always sized for the largest port index space.
  localparam int MAX_DESTS      = 4;

  typedef logic [ROUTE_BITS-1:0]   route_word_t;
  typedef logic [ROUTE_UL_W-1:0]   route_ul_t;
  typedef logic [ROUTE_PORT_W-1:0] route_port_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } gate_sched_state_t;

  function automatic route_ul_t route_ul(input route_word_t w);
    return w[ROUTE_UL_LSB +: ROUTE_UL_W];
  endfunction

  function automatic route_port_t route_port(input route_word_t w);
    return w[ROUTE_PORT_LSB +: ROUTE_PORT_W];
  endfunction

endpackage

// File: rtl/gate_route_sched_arb.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr (wrapping), returning a one-hot grant and its index.
module gate_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] cand_s;

  // Cyclic scan from ptr; the first hit wins and later hits are ignored
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_s      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[cand_s] && !grant_valid) begin
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
        grant_valid   = 1'b1;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/gate_route_sched.sv
// Route capability gate: owns the per-port ul_id table, serialises host
// table writes and requester lookups through one lookup engine, and returns
// allow/deny results over a valid/ready response channel.
module gate_route_sched
  import gate_route_sched_pkg::*;
#(
  parameter int N_DESTS        = 4,
  parameter int N_REQ          = 4,
  parameter int MAX_CTRL_BURST = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        ctrl_valid,
  output logic                        ctrl_ready,
  input  logic [ROUTE_BITS-1:0]       ctrl_data,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*ROUTE_BITS-1:0] req_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(N_REQ)-1:0]    rsp_req_id,
  output logic [1:0]                  rsp_port,
  output logic                        rsp_allow,
  output logic [31:0]                 deny_cnt
);

  localparam int                  IDX_W     = $clog2(N_REQ);
  localparam int                  BURST_W   = $clog2(MAX_CTRL_BURST + 1);
  localparam logic [BURST_W-1:0]  BURST_MAX = BURST_W'(MAX_CTRL_BURST);
  localparam logic [BURST_W-1:0]  BURST_ONE = BURST_W'(1);
  localparam logic [IDX_W-1:0]    LAST_REQ  = IDX_W'(N_REQ - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
  localparam logic [31:0]         DENY_MAX  = 32'hFFFF_FFFF;

  gate_sched_state_t state_r;
  gate_sched_state_t state_nxt_s;
  route_ul_t         table_r [MAX_DESTS];
  logic [IDX_W-1:0]  rr_ptr_r;
  logic [BURST_W-1:0] ctrl_burst_r;
  route_word_t       lat_word_r;
  logic [IDX_W-1:0]  lat_id_r;

  logic              any_req_s;
  logic              ctrl_take_s;
  logic              req_take_s;
  logic [N_REQ-1:0]  arb_grant_s;
  logic [IDX_W-1:0]  arb_idx_s;
  logic              arb_valid_s;
  route_word_t       arb_word_s;
  route_port_t       wr_port_s;
  logic              wr_in_range_s;
  route_port_t       lk_port_s;
  logic              lk_allow_s;

  gate_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr_r),
    .grant       (arb_grant_s),
    .grant_idx   (arb_idx_s),
    .grant_valid (arb_valid_s)
  );

  // Select the granted requester's route word (grant is one-hot)
  always_comb begin
    arb_word_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant_s[i]) begin
        arb_word_s = req_data[i*ROUTE_BITS +: ROUTE_BITS];
      end else begin
        arb_word_s = arb_word_s;
      end
    end
  end

  // Decode the host write target and the lookup verdict for the latched word
  always_comb begin
    wr_port_s     = route_port(ctrl_data);
    wr_in_range_s = (int'(wr_port_s) < N_DESTS);
    lk_port_s     = route_port(lat_word_r);
    if (int'(lk_port_s) < N_DESTS) begin
      lk_allow_s = (route_ul(lat_word_r) == table_r[lk_port_s]);
    end else begin
      lk_allow_s = 1'b0;
    end
  end

  // Arbitration and next-state: host writes win until their burst budget
  // runs out while a requester is waiting
  always_comb begin
    any_req_s   = |req_valid;
    ctrl_take_s = 1'b0;
    req_take_s  = 1'b0;
    ctrl_ready  = 1'b0;
    req_ready   = '0;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ctrl_valid && (!any_req_s || (ctrl_burst_r < BURST_MAX))) begin
          ctrl_ready  = 1'b1;
          ctrl_take_s = 1'b1;
          state_nxt_s = IDLE;
        end else if (arb_valid_s) begin
          req_ready   = arb_grant_s;
          req_take_s  = 1'b1;
          state_nxt_s = LOOKUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOOKUP: begin
        state_nxt_s = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Scheduler state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capability table: accepted in-range host writes update one entry
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < MAX_DESTS; i++) begin
        table_r[i] <= '0;
      end
    end else if (ctrl_take_s && wr_in_range_s) begin
      table_r[wr_port_s] <= route_ul(ctrl_data);
    end
  end

  // Fairness bookkeeping and capture of the granted request
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr_ptr_r     <= '0;
      ctrl_burst_r <= '0;
      lat_word_r   <= '0;
      lat_id_r     <= '0;
    end else if (ctrl_take_s) begin
      if (!any_req_s) begin
        ctrl_burst_r <= '0;
      end else if (ctrl_burst_r != BURST_MAX) begin
        ctrl_burst_r <= ctrl_burst_r + BURST_ONE;
      end
    end else if (req_take_s) begin
      lat_word_r   <= arb_word_s;
      lat_id_r     <= arb_idx_s;
      rr_ptr_r     <= (arb_idx_s == LAST_REQ) ? '0 : (arb_idx_s + IDX_ONE);
      ctrl_burst_r <= '0;
    end
  end

  // Response registers and saturating deny counter
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rsp_valid  <= 1'b0;
      rsp_req_id <= '0;
      rsp_port   <= '0;
      rsp_allow  <= 1'b0;
      deny_cnt   <= '0;
    end else if (state_r == LOOKUP) begin
      rsp_valid  <= 1'b1;
      rsp_req_id <= lat_id_r;
      rsp_port   <= lk_port_s;
      rsp_allow  <= lk_allow_s;
      if (!lk_allow_s && (deny_cnt != DENY_MAX)) begin
        deny_cnt <= deny_cnt + 32'd1;
      end
    end else if ((state_r == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
